// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer. Collects WIDTH enabled samples of iSignal
// into an assembly register and publishes the finished word with a one-cycle valid pulse.
module serial_deser #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic                         iSignal,
  input  logic                         iEnable,
  input  logic                         iStart,
  output logic [WIDTH-1:0]             oVector,
  output logic                         oValid,
  output logic                         oBusy,
  output logic [$clog2(WIDTH+1)-1:0]   oCount
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  asm_q, asm_d;
  logic [WIDTH-1:0]  vector_q, vector_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  word_s;

  // Assembly is kept in frame order (bit k at index k); reorder only on publish.
  function automatic logic [WIDTH-1:0] map_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        r[WIDTH-1-i] = w[i];
      end
    end else begin
      r = w;
    end
    return r;
  endfunction

  // Next-state logic: start/restart, sample collection and word completion.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    asm_d    = asm_q;
    vector_d = vector_q;
    valid_d  = 1'b0;
    word_s   = asm_q;

    for (int i = 0; i < WIDTH; i++) begin
      if (count_q == CW'(i)) begin
        word_s[i] = iSignal;
      end else begin
        word_s[i] = asm_q[i];
      end
    end

    if (iStart) begin
      state_d = ST_CAPTURE;
      if (iEnable) begin
        asm_d   = {{(WIDTH-1){1'b0}}, iSignal};
        count_d = CW'(1);
      end else begin
        asm_d   = '0;
        count_d = '0;
      end
    end else if ((state_q == ST_CAPTURE) && iEnable) begin
      if (count_q == CW'(WIDTH-1)) begin
        vector_d = map_word(word_s);
        valid_d  = 1'b1;
        count_d  = '0;
        asm_d    = '0;
        if (CONTINUOUS != 0) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        asm_d   = word_s;
        count_d = count_q + CW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      asm_q    <= '0;
      vector_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      asm_q    <= asm_d;
      vector_q <= vector_d;
      valid_q  <= valid_d;
    end
  end

  assign oVector = vector_q;
  assign oValid  = valid_q;
  assign oBusy   = (state_q == ST_CAPTURE);
  assign oCount  = count_q;

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: three WIDTH=8 instances (LSB-first, MSB-first,
// continuous) share one stimulus stream; each test checks the instance it targets.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       rst_n, sig, en, start;
  logic [7:0] o0_vec, o1_vec, o2_vec;
  logic       o0_valid, o1_valid, o2_valid;
  logic       o0_busy, o1_busy, o2_busy;
  logic [3:0] o0_cnt, o1_cnt, o2_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(0), .CONTINUOUS(0)) dut0 (
    .iClk(clk), .iReset_n(rst_n), .iSignal(sig), .iEnable(en), .iStart(start),
    .oVector(o0_vec), .oValid(o0_valid), .oBusy(o0_busy), .oCount(o0_cnt));

  serial_deser #(.WIDTH(8), .MSB_FIRST(1), .CONTINUOUS(0)) dut1 (
    .iClk(clk), .iReset_n(rst_n), .iSignal(sig), .iEnable(en), .iStart(start),
    .oVector(o1_vec), .oValid(o1_valid), .oBusy(o1_busy), .oCount(o1_cnt));

  serial_deser #(.WIDTH(8), .MSB_FIRST(0), .CONTINUOUS(1)) dut2 (
    .iClk(clk), .iReset_n(rst_n), .iSignal(sig), .iEnable(en), .iStart(start),
    .oVector(o2_vec), .oValid(o2_valid), .oBusy(o2_busy), .oCount(o2_cnt));

  // Apply inputs, take one rising edge, return 1 time unit after it.
  task automatic drive(input logic s, input logic e, input logic d);
    start = s; en = e; sig = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    vectors++; if (o0_vec !== 8'h00)  begin miscompares++; $display("FAIL reset_vec got %h want 00", o0_vec); end
    vectors++; if (o0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o0_valid); end
    vectors++; if (o0_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got %b want 0", o0_busy); end
    vectors++; if (o0_cnt !== 4'd0)   begin miscompares++; $display("FAIL reset_count got %0d want 0", o0_cnt); end
    vectors++; if (o2_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy_cont got %b want 0", o2_busy); end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1);
    vectors++; if (o0_busy !== 1'b0)  begin miscompares++; $display("FAIL idle_ignores_enable busy got %b want 0", o0_busy); end
    vectors++; if (o0_cnt !== 4'd0)   begin miscompares++; $display("FAIL idle_ignores_enable count got %0d want 0", o0_cnt); end
  endtask

  task automatic test_lsb_msb;
    logic [7:0] w;
    int pulses;
    w = 8'h4D;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, 1'b1, w[k]);
      if (o0_valid) pulses++;
      if (k < 7) begin
        vectors++; if (o0_cnt !== 4'(k+1)) begin miscompares++; $display("FAIL lsb_count k=%0d got %0d want %0d", k, o0_cnt, k+1); end
        vectors++; if (o0_busy !== 1'b1)   begin miscompares++; $display("FAIL lsb_busy k=%0d got %b want 1", k, o0_busy); end
      end
    end
    vectors++; if (o0_vec !== 8'h4D)  begin miscompares++; $display("FAIL lsb_word got %h want 4d", o0_vec); end
    vectors++; if (o1_vec !== 8'hB2)  begin miscompares++; $display("FAIL msb_word got %h want b2", o1_vec); end
    vectors++; if (o1_valid !== 1'b1) begin miscompares++; $display("FAIL msb_valid got %b want 1", o1_valid); end
    vectors++; if (o0_busy !== 1'b0)  begin miscompares++; $display("FAIL lsb_busy_after got %b want 0", o0_busy); end
    vectors++; if (o0_cnt !== 4'd0)   begin miscompares++; $display("FAIL lsb_count_after got %0d want 0", o0_cnt); end
    drive(1'b0, 1'b0, 1'b0);
    if (o0_valid) pulses++;
    vectors++; if (pulses !== 1)      begin miscompares++; $display("FAIL lsb_pulses got %0d want 1", pulses); end
    vectors++; if (o0_vec !== 8'h4D)  begin miscompares++; $display("FAIL lsb_word_hold got %h want 4d", o0_vec); end
  endtask

  task automatic test_abort;
    int pulses;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, 1'b1, k[0] ? 1'b0 : 1'b1);
      if (o0_valid) pulses++;
    end
    vectors++; if (o0_cnt !== 4'd5)   begin miscompares++; $display("FAIL abort_partial_count got %0d want 5", o0_cnt); end
    drive(1'b1, 1'b1, 1'b1);
    if (o0_valid) pulses++;
    vectors++; if (o0_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", o0_valid); end
    vectors++; if (o0_vec !== 8'h4D)  begin miscompares++; $display("FAIL abort_vec_hold got %h want 4d", o0_vec); end
    vectors++; if (o0_cnt !== 4'd1)   begin miscompares++; $display("FAIL abort_count got %0d want 1", o0_cnt); end
    vectors++; if (o0_busy !== 1'b1)  begin miscompares++; $display("FAIL abort_busy got %b want 1", o0_busy); end
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b1);
      if (o0_valid) pulses++;
    end
    vectors++; if (o0_vec !== 8'hFF)  begin miscompares++; $display("FAIL abort_refill_word got %h want ff", o0_vec); end
    vectors++; if (o0_valid !== 1'b1) begin miscompares++; $display("FAIL abort_refill_valid got %b want 1", o0_valid); end
    vectors++; if (pulses !== 1)      begin miscompares++; $display("FAIL abort_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_enable_gaps;
    logic [7:0] w;
    int pulses;
    w = 8'h4D;
    pulses = 0;
    drive(1'b1, 1'b1, w[0]);
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b0, ~w[k]);
      if (o0_valid) pulses++;
      vectors++; if (o0_cnt !== 4'(k)) begin miscompares++; $display("FAIL gap_count_hold k=%0d got %0d want %0d", k, o0_cnt, k); end
      drive(1'b0, 1'b1, w[k]);
      if (o0_valid) pulses++;
    end
    vectors++; if (o0_vec !== 8'h4D)  begin miscompares++; $display("FAIL gap_word got %h want 4d", o0_vec); end
    vectors++; if (o0_valid !== 1'b1) begin miscompares++; $display("FAIL gap_valid got %b want 1", o0_valid); end
    vectors++; if (pulses !== 1)      begin miscompares++; $display("FAIL gap_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] s;
    int first, second, pulses;
    s = 16'h3CA5;
    first = -1; second = -1; pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      drive(c == 1, 1'b1, s[c-1]);
      vectors++; if (o2_busy !== 1'b1) begin miscompares++; $display("FAIL cont_busy cyc=%0d got %b want 1", c, o2_busy); end
      if (o2_valid) begin
        pulses++;
        if (first < 0) first = c; else second = c;
        if (c == 8) begin
          vectors++; if (o2_vec !== 8'hA5) begin miscompares++; $display("FAIL cont_word1 got %h want a5", o2_vec); end
        end
      end
      if (c == 10) begin
        vectors++; if (o0_busy !== 1'b0) begin miscompares++; $display("FAIL noncont_idle_busy got %b want 0", o0_busy); end
      end
    end
    vectors++; if (pulses !== 2)           begin miscompares++; $display("FAIL cont_pulses got %0d want 2", pulses); end
    vectors++; if (first !== 8)            begin miscompares++; $display("FAIL cont_first_cycle got %0d want 8", first); end
    vectors++; if (second - first !== 8)   begin miscompares++; $display("FAIL cont_spacing got %0d want 8", second - first); end
    vectors++; if (o2_vec !== 8'h3C)       begin miscompares++; $display("FAIL cont_word2 got %h want 3c", o2_vec); end
    vectors++; if (o2_cnt !== 4'd0)        begin miscompares++; $display("FAIL cont_count got %0d want 0", o2_cnt); end
    vectors++; if (o0_vec !== 8'hA5)       begin miscompares++; $display("FAIL noncont_word got %h want a5", o0_vec); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    int pulses;
    w = 8'h36;
    pulses = 0;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    vectors++; if (o0_vec !== 8'h00)  begin miscompares++; $display("FAIL mid_reset_vec got %h want 00", o0_vec); end
    vectors++; if (o0_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %b want 0", o0_valid); end
    vectors++; if (o0_busy !== 1'b0)  begin miscompares++; $display("FAIL mid_reset_busy got %b want 0", o0_busy); end
    vectors++; if (o0_cnt !== 4'd0)   begin miscompares++; $display("FAIL mid_reset_count got %0d want 0", o0_cnt); end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, 1'b1, w[k]);
      if (o0_valid) pulses++;
    end
    vectors++; if (o0_vec !== 8'h36)  begin miscompares++; $display("FAIL post_reset_word got %h want 36", o0_vec); end
    vectors++; if (o1_vec !== 8'h6C)  begin miscompares++; $display("FAIL post_reset_msb_word got %h want 6c", o1_vec); end
    vectors++; if (pulses !== 1)      begin miscompares++; $display("FAIL post_reset_pulses got %0d want 1", pulses); end
  endtask

  initial begin
    rst_n = 1'b0; sig = 1'b0; en = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_lsb_msb();
    test_abort();
    test_enable_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
